// File: rtl/exc_ctrl.sv
// Exception/interrupt front-end for the cdm16 core: arbitrates internal exceptions
// and one vectored IRQ, holds the winner until an instruction boundary, tracks nesting.
module exc_ctrl #(
  parameter int EXC_COUNT = 4,
  parameter int IRQ_VEC_W = 6,
  parameter int MAX_DEPTH = 7
) (
  input  logic                 input_clock,
  input  logic                 reset_n,
  input  logic [EXC_COUNT-1:0] exc_req,
  input  logic                 irq_req,
  input  logic [IRQ_VEC_W-1:0] irq_vec,
  output logic                 irq_ack,
  input  logic                 int_en,
  input  logic                 fetch,
  input  logic                 int_done,
  input  logic                 rti,
  output logic                 exc_triggered,
  output logic                 virtual_instruction,
  output logic [15:0]          vec_addr,
  output logic                 in_irq,
  output logic                 critical_fault,
  output logic [2:0]           depth,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, ENTRY = 2'd2, FAULT = 2'd3} state_t;

  localparam logic [2:0] MAXD = 3'(MAX_DEPTH);

  state_t               state_q, state_d;
  logic                 src_irq_q, src_irq_d;
  logic [IRQ_VEC_W-1:0] vec_q, vec_d;
  logic [2:0]           depth_q, depth_d;
  logic                 exc_any;
  logic [IRQ_VEC_W-1:0] exc_idx;

  assign exc_any = |exc_req;

  // Lowest set index wins, so scan from the top and let later hits overwrite.
  always_comb begin
    exc_idx = '0;
    for (int i = EXC_COUNT - 1; i >= 0; i--) begin
      if (exc_req[i]) exc_idx = IRQ_VEC_W'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    src_irq_d = src_irq_q;
    vec_d     = vec_q;
    case (state_q)
      IDLE: begin
        if (exc_any) begin
          state_d   = PEND;
          src_irq_d = 1'b0;
          vec_d     = exc_idx;
        end else if (irq_req && int_en) begin
          state_d   = PEND;
          src_irq_d = 1'b1;
          vec_d     = irq_vec;
        end
      end
      PEND: begin
        // An exception displaces a latched IRQ; the IRQ stays requested, unacked.
        if (src_irq_q && exc_any) begin
          src_irq_d = 1'b0;
          vec_d     = exc_idx;
        end
        if (src_irq_d && !int_en) state_d = IDLE;
        else if (fetch)           state_d = (depth_q == MAXD) ? FAULT : ENTRY;
      end
      ENTRY: begin
        if (exc_any)       state_d = FAULT;
        else if (int_done) state_d = IDLE;
      end
      default: state_d = FAULT;
    endcase
  end

  always_comb begin
    depth_d = depth_q;
    if (state_q != FAULT) begin
      if (state_q == ENTRY && state_d == IDLE) begin
        if (!rti) depth_d = depth_q + 3'd1;
      end else if (rti && depth_q != 3'd0) begin
        depth_d = depth_q - 3'd1;
      end
    end
  end

  always_ff @(negedge input_clock) begin
    if (!reset_n) begin
      state_q             <= IDLE;
      src_irq_q           <= 1'b0;
      vec_q               <= '0;
      depth_q             <= '0;
      irq_ack             <= 1'b0;
      exc_triggered       <= 1'b0;
      virtual_instruction <= 1'b0;
      vec_addr            <= '0;
      critical_fault      <= 1'b0;
    end else begin
      state_q             <= state_d;
      src_irq_q           <= src_irq_d;
      vec_q               <= vec_d;
      depth_q             <= depth_d;
      irq_ack             <= (state_q == PEND) && (state_d == ENTRY) && src_irq_d;
      exc_triggered       <= (state_d == ENTRY);
      virtual_instruction <= (state_d == ENTRY) && src_irq_d;
      vec_addr            <= (state_d == PEND || state_d == ENTRY) ? (16'(vec_d) << 2) : 16'd0;
      critical_fault      <= (state_d == FAULT);
    end
  end

  // Kept outside the FSM so a core parked in its wait state can be woken.
  assign in_irq    = irq_req && int_en && (state_q != FAULT);
  assign depth     = depth_q;
  assign state_dbg = state_q;

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception and interrupt front-end that sits directly upstream of the cdm16 core.
- Arbitrates internal exception requests and one external vectored IRQ line, and holds the winning request until the core reaches an instruction boundary.
- Drives the core's exc_triggered, virtual_instruction, in_irq and critical_fault inputs, plus the vector address used by the entry microcode.
- Tracks service nesting depth and escalates double faults to a sticky critical fault.

Parameters:
EXC_COUNT, 4, number of internal exception sources; index 0 has the highest priority; vector number = index.
IRQ_VEC_W, 6, width of the external IRQ vector number.
MAX_DEPTH, 7, maximum nesting depth; an entry attempted at MAX_DEPTH is a critical fault.

Ports:
input_clock  in  1  system clock; all state updates on the negedge, matching the core.
reset_n  in  1  synchronous, active-low reset.
exc_req  in  EXC_COUNT  level exception requests from the core/decoder.
irq_req  in  1  external interrupt request; held by the requester until irq_ack.
irq_vec  in  IRQ_VEC_W  vector number, valid while irq_req=1.
irq_ack  out  1  one-cycle acceptance pulse for the IRQ.
int_en  in  1  PS[15] from the core.
fetch  in  1  core is at an instruction boundary.
int_done  in  1  core's _int: entry sequence complete.
rti  in  1  core's rti: return from service.
exc_triggered  out  1  entry request to the core.
virtual_instruction  out  1  1 = entry has no faulting instruction (IRQ), so the PC is not rewound.
vec_addr  out  16  {vector, 2'b00}, zero-extended.
in_irq  out  1  wake signal for the core's wait state.
critical_fault  out  1  sticky fault to the core.
depth  out  3  current nesting depth.

Behaviour:
- Reset: on any negedge with reset_n=0, every register clears in the same cycle, regardless of state.
  - state=IDLE, depth=0, latched source/vector=0.
  - All outputs 0, including critical_fault.
  - A pending IRQ is dropped without an ack.
- States: IDLE, PEND, ENTRY, FAULT.
- IDLE:
  - Any exc_req bit set → PEND with source=EXC, vector=lowest set index.
  - Otherwise, irq_req & int_en → PEND with source=IRQ, vector=irq_vec.
  - Exceptions win when both are present on the same edge.
- PEND:
  - The request is latched; exc_req/irq_vec changes do not alter it.
  - Exception preemption: a new exc_req while the latched source is IRQ replaces it (source=EXC). No ack is given, and the IRQ stays requested.
  - IRQ withdrawal: if the latched source is IRQ and int_en drops, return to IDLE.
  - On an edge with fetch=1:
    - depth==MAX_DEPTH → FAULT.
    - Otherwise → ENTRY. irq_ack=1 for exactly that following cycle if source=IRQ.
- ENTRY:
  - exc_triggered=1.
  - virtual_instruction = (source==IRQ).
  - vec_addr is valid and stable.
  - At an edge with int_done=1 → IDLE and depth+1.
  - A new exc_req arriving during ENTRY (double fault) → FAULT.
- FAULT:
  - critical_fault=1, held until reset.
  - exc_triggered=0, irq_ack never asserted, depth frozen.
- rti:
  - In any state except FAULT, an rti at an edge with depth>0 does depth−1.
  - rti at depth 0 is ignored (no underflow).
  - int_done and rti on the same edge: net depth change is 0.
- in_irq is combinational: irq_req & int_en & (state != FAULT). It is independent of the state machine so it can wake a waiting core.
- vec_addr = 0 outside PEND/ENTRY. Outputs other than in_irq are registered.
- Latency:
  - Request to PEND: 1 edge.
  - PEND to exc_triggered: 1 edge after fetch is sampled.

Test Plan:
1. Reset mid-operation: reset_n=0 while in ENTRY with source=IRQ → next cycle exc_triggered=0, irq_ack never pulses, depth=0.
2. IRQ entry: int_en=1, irq_req=1, irq_vec=5, then fetch=1 → irq_ack one cycle; exc_triggered=1, virtual_instruction=1, vec_addr=0x0014; int_done → depth=1; rti → depth=0.
3. Priority and preemption:
   - exc_req=4'b1010 together with irq_req → vec_addr=0x0004, virtual_instruction=0, no irq_ack.
   - After the exception is serviced, the still-held IRQ is taken.
4. Double fault: exc_req[2] asserted while in ENTRY → critical_fault=1; it stays 1 with later rti/fetch/irq until reset_n=0.
5. Depth saturation:
   - Seven nested IRQ entries with no rti → depth=7.
   - An eighth request reaching fetch → FAULT.
   - rti at depth 0 leaves depth=0.
6. Masking and wake: int_en=0, irq_req=1 → in_irq=0, state stays IDLE; raise int_en → in_irq=1 the same cycle, PEND on the next edge.
